tug_light_bar: RTL and testbench

//  Parametrised tug-of-war playfield: NUM_LIGHTS lights, exactly one lit in play.

---
 rtl/tug_light_bar.sv | 153 +++++++++++++++
 tb/tb_tug_light_bar.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tug_light_bar.sv
// tug_light_bar: tug-of-war playfield with one lit light that moves with the key presses.
// A position register tracks the lit light. The block also keeps one score counter per side.
// A round restarts on a timer after each win, and the match ends when a side reaches
// MAX_SCORE. Every game register advances only on cycles where the tick strobe ce is high.
module tug_light_bar #(
   parameter int NUM_LIGHTS  = 9,
   parameter int SCORE_W     = 3,
   parameter int MAX_SCORE   = 7,
   parameter int RESTART_TKS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  key_l,
   input  logic                  key_r,
   output logic [NUM_LIGHTS-1:0] lights,
   output logic                  win_l,
   output logic                  win_r,
   output logic [SCORE_W-1:0]    score_l,
   output logic [SCORE_W-1:0]    score_r,
   output logic                  game_over
);

   localparam int CENTRE = (NUM_LIGHTS - 1) / 2;
   localparam int POS_W  = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
   localparam int CNT_W  = (RESTART_TKS > 1) ? $clog2(RESTART_TKS) : 1;

   localparam logic [POS_W-1:0]   POS_C     = POS_W'(CENTRE);
   localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(NUM_LIGHTS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);
   localparam logic [SCORE_W-1:0] SCORE_PEN = SCORE_W'(MAX_SCORE - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(RESTART_TKS - 1);

   localparam logic [1:0] ST_PLAY  = 2'd0;
   localparam logic [1:0] ST_WIN_L = 2'd1;
   localparam logic [1:0] ST_WIN_R = 2'd2;

   // Reject parameter sets the game cannot represent.
   if ((NUM_LIGHTS < 3) || (NUM_LIGHTS % 2 == 0)) begin : g_bad_lights
      $error("tug_light_bar: NUM_LIGHTS must be odd and >= 3");
   end
   if ((MAX_SCORE < 1) || (MAX_SCORE > (2 ** SCORE_W) - 1)) begin : g_bad_score
      $error("tug_light_bar: MAX_SCORE out of range for SCORE_W");
   end
   if (RESTART_TKS < 1) begin : g_bad_restart
      $error("tug_light_bar: RESTART_TKS must be >= 1");
   end

   logic [1:0]         state,     state_nx;
   logic [POS_W-1:0]   pos,       pos_nx;
   logic [CNT_W-1:0]   cnt,       cnt_nx;
   logic [SCORE_W-1:0]            score_l_nx, score_r_nx;
   logic                          game_over_nx;
   logic               prev_l,    prev_r;
   logic               press_l,   press_r;
   logic               mv_l,      mv_r;

   // Rising-edge presses, qualified by the tick. If both keys are pressed on the same tick, they cancel.
   always_comb begin
      press_l = ce & key_l & ~prev_l;
      press_r = ce & key_r & ~prev_r;
      mv_l    = press_l & ~press_r;
      mv_r    = press_r & ~press_l;
   end

   // Next-state logic for the play/win machine, the position, the restart timer and the scores.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave a latch.
      state_nx     = state;
      pos_nx       = pos;
      cnt_nx       = cnt;
      score_l_nx   = score_l;
      score_r_nx   = score_r;
      game_over_nx = game_over;
      if (ce) begin
         case (state)
            ST_PLAY: begin
               if (mv_r) begin
                  if (pos == POS_MAX) begin
                     state_nx = ST_WIN_R;
                     cnt_nx   = '0;
                     if (score_r != SCORE_MAX) score_r_nx = score_r + SCORE_W'(1);
                     if (score_r == SCORE_PEN) game_over_nx = 1'b1;
                  end else begin
                     pos_nx = pos + POS_W'(1);
                  end
               end else if (mv_l) begin
                  if (pos == '0) begin
                     state_nx = ST_WIN_L;
                     cnt_nx   = '0;
                     if (score_l != SCORE_MAX) score_l_nx = score_l + SCORE_W'(1);
                     if (score_l == SCORE_PEN) game_over_nx = 1'b1;
                  end else begin
                     pos_nx = pos - POS_W'(1);
                  end
               end
            end
            ST_WIN_L, ST_WIN_R: begin
               // After the final round the win display stays frozen until reset.
               if (!game_over) begin
                  if (cnt == CNT_LAST) begin
                     state_nx = ST_PLAY;
                     pos_nx   = POS_C;
                     cnt_nx   = '0;
                  end else begin
                     cnt_nx = cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_nx = ST_PLAY;
               pos_nx   = POS_C;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   // State registers with synchronous reset. The key-history registers sample only on tick cycles.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state     <= ST_PLAY;
         pos       <= POS_C;
         cnt       <= '0;
         prev_l    <= 1'b0;
         prev_r    <= 1'b0;
         score_l   <= '0;
         score_r   <= '0;
         game_over <= 1'b0;
      end else begin
         state     <= state_nx;
         pos       <= pos_nx;
         cnt       <= cnt_nx;
         score_l   <= score_l_nx;
         score_r   <= score_r_nx;
         game_over <= game_over_nx;
         if (ce) begin
            prev_l <= key_l;
            prev_r <= key_r;
         end
      end
   end

   // Decode the display outputs from the registered state only, so no key input reaches an output combinationally.
   always_comb begin
      lights = '0;
      if (state == ST_PLAY) lights = NUM_LIGHTS'(1) << pos;
      win_l = (state == ST_WIN_L);
      win_r = (state == ST_WIN_R);
   end

endmodule

// File: tb/tb_tug_light_bar.sv
// tb_tug_light_bar: directed vectors for a 5-light bar with MAX_SCORE=2 and RESTART_TKS=2.
// The stimulus process queues the expected outputs for each vector. The monitor process
// compares the outputs just after the clock edge that consumes that vector.
module tb_tug_light_bar;

   localparam int NL = 5;
   localparam int SW = 3;

   typedef struct {
      logic          rst;
      logic          ce;
      logic          kl;
      logic          kr;
      logic [NL-1:0] lights;
      logic          wl;
      logic          wr;
      logic [SW-1:0] sl;
      logic [SW-1:0] sr;
      logic          go;
      string         name;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ce = 1'b0;
   logic          key_l = 1'b0;
   logic          key_r = 1'b0;
   logic [NL-1:0] lights;
   logic          win_l, win_r, game_over;
   logic [SW-1:0] score_l, score_r;

   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   tug_light_bar #(
      .NUM_LIGHTS (NL),
      .SCORE_W    (SW),
      .MAX_SCORE  (2),
      .RESTART_TKS(2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ce       (ce),
      .key_l    (key_l),
      .key_r    (key_r),
      .lights   (lights),
      .win_l    (win_l),
      .win_r    (win_r),
      .score_l  (score_l),
      .score_r  (score_r),
      .game_over(game_over)
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   // Drive one vector away from the rising edge and queue its expected post-edge outputs.
   task automatic v(input logic rst, input logic c, input logic kl, input logic kr,
                    input logic [NL-1:0] li, input logic wl, input logic wr,
                    input logic [SW-1:0] sl, input logic [SW-1:0] sr, input logic go,
                    input string name);
      vec_t e;
      @(negedge clk);
      reset = rst;
      ce    = c;
      key_l = kl;
      key_r = kr;
      e.rst = rst; e.ce = c; e.kl = kl; e.kr = kr;
      e.lights = li; e.wl = wl; e.wr = wr; e.sl = sl; e.sr = sr; e.go = go; e.name = name;
      exp_q.push_back(e);
   endtask

   // Monitor: compare every queued expectation one time unit after the edge that consumed it.
   initial begin
      vec_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(e);
         end
      end
   end

   task automatic check(input vec_t e);
      n_vec++;
      if ({lights, win_l, win_r, score_l, score_r, game_over} !==
          {e.lights, e.wl, e.wr, e.sl, e.sr, e.go}) begin
         n_bad++;
         $display("FAIL %s: got lights=%b wl=%b wr=%b sl=%0d sr=%0d go=%b, want lights=%b wl=%b wr=%b sl=%0d sr=%0d go=%b",
                  e.name, lights, win_l, win_r, score_l, score_r, game_over,
                  e.lights, e.wl, e.wr, e.sl, e.sr, e.go);
      end
   endtask

   // Directed scenarios with hand-computed expected outputs.
   initial begin
      // Reset state
      v(1,1,0,0, 5'b00100,0,0,0,0,0, "reset_a");
      v(1,1,0,0, 5'b00100,0,0,0,0,0, "reset_b");
      // Single pulse, then hold: the held key gives exactly one move
      v(0,1,0,1, 5'b01000,0,0,0,0,0, "pulse_r");
      v(0,1,0,0, 5'b01000,0,0,0,0,0, "pulse_r_rel");
      v(0,1,0,1, 5'b10000,0,0,0,0,0, "hold_r_1");
      for (int i = 0; i < 4; i++) v(0,1,0,1, 5'b10000,0,0,0,0,0, "hold_r_n");
      v(0,1,0,0, 5'b10000,0,0,0,0,0, "hold_r_rel");
      // Back to the centre with two left pulses
      v(0,1,1,0, 5'b01000,0,0,0,0,0, "left_1");
      v(0,1,0,0, 5'b01000,0,0,0,0,0, "left_1_rel");
      v(0,1,1,0, 5'b00100,0,0,0,0,0, "left_2");
      v(0,1,0,0, 5'b00100,0,0,0,0,0, "left_2_rel");
      // Simultaneous rise: no move
      v(0,1,1,1, 5'b00100,0,0,0,0,0, "both_rise");
      v(0,1,0,0, 5'b00100,0,0,0,0,0, "both_rel");
      // Right walks off the end and wins; keys are ignored during WIN; timed restart
      v(0,1,0,1, 5'b01000,0,0,0,0,0, "walk_r1");
      v(0,1,0,0, 5'b01000,0,0,0,0,0, "walk_r1_rel");
      v(0,1,0,1, 5'b10000,0,0,0,0,0, "walk_r2");
      v(0,1,0,0, 5'b10000,0,0,0,0,0, "walk_r2_rel");
      v(0,1,0,1, 5'b00000,0,1,0,1,0, "win_r_enter");
      v(0,1,1,0, 5'b00000,0,1,0,1,0, "win_r_key_ignored");
      v(0,1,0,0, 5'b00100,0,0,0,1,0, "win_r_restart");
      // ce=0 freezes everything; a key held across ce=0 moves once on the tick
      v(0,0,0,1, 5'b00100,0,0,0,1,0, "ce0_pulse");
      v(0,0,0,0, 5'b00100,0,0,0,1,0, "ce0_rel");
      v(0,0,0,1, 5'b00100,0,0,0,1,0, "ce0_hold_a");
      v(0,0,0,1, 5'b00100,0,0,0,1,0, "ce0_hold_b");
      v(0,1,0,1, 5'b01000,0,0,0,1,0, "ce1_after_hold");
      v(0,1,0,1, 5'b01000,0,0,0,1,0, "ce1_still_held");
      v(0,1,0,0, 5'b01000,0,0,0,1,0, "ce1_rel");
      // Left walks from pos 3 to a left win; ce=0 inside WIN holds the restart timer
      v(0,1,1,0, 5'b00100,0,0,0,1,0, "walk_l1");
      v(0,1,0,0, 5'b00100,0,0,0,1,0, "walk_l1_rel");
      v(0,1,1,0, 5'b00010,0,0,0,1,0, "walk_l2");
      v(0,1,0,0, 5'b00010,0,0,0,1,0, "walk_l2_rel");
      v(0,1,1,0, 5'b00001,0,0,0,1,0, "walk_l3");
      v(0,1,0,0, 5'b00001,0,0,0,1,0, "walk_l3_rel");
      v(0,1,1,0, 5'b00000,1,0,1,1,0, "win_l_enter");
      v(0,0,0,0, 5'b00000,1,0,1,1,0, "win_l_ce0_hold");
      v(0,1,0,0, 5'b00000,1,0,1,1,0, "win_l_tick1");
      v(0,1,0,0, 5'b00100,0,0,1,1,0, "win_l_restart");
      // Right's second win ends the match; WIN is then frozen and keys are ignored
      v(0,1,0,1, 5'b01000,0,0,1,1,0, "final_r1");
      v(0,1,0,0, 5'b01000,0,0,1,1,0, "final_r1_rel");
      v(0,1,0,1, 5'b10000,0,0,1,1,0, "final_r2");
      v(0,1,0,0, 5'b10000,0,0,1,1,0, "final_r2_rel");
      v(0,1,0,1, 5'b00000,0,1,1,2,1, "game_over_enter");
      for (int i = 0; i < 3; i++) begin
         v(0,1,0,0, 5'b00000,0,1,1,2,1, "game_over_hold");
         v(0,1,1,1, 5'b00000,0,1,1,2,1, "game_over_keys");
         v(0,1,0,0, 5'b00000,0,1,1,2,1, "game_over_rel");
         v(0,1,0,1, 5'b00000,0,1,1,2,1, "game_over_key_r");
      end
      // Reset from inside the frozen WIN state restores the reset values
      v(1,1,0,0, 5'b00100,0,0,0,0,0, "reset_after_over");
      v(0,1,0,1, 5'b01000,0,0,0,0,0, "play_after_reset");
      v(0,1,0,0, 5'b01000,0,0,0,0,0, "play_after_reset_rel");

      // Let the monitor drain the queue, but wait only a bounded number of cycles.
      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
